// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU snoop side, the system bus mux and the sprite-DMA engine.
// The master modport is the DMA engine; the slave modport is the CPU/bus-mux side.
interface oam_dma_if;
    logic [15:0] cpu_Addr_bus;
    logic [7:0]  cpu_Data_bus_out;
    logic        cpu_R_nW;
    logic [7:0]  Data_bus_in;
    logic        rdy;
    logic        bus_sel;
    logic [15:0] dma_Addr_bus;
    logic [7:0]  dma_Data_bus_out;
    logic        dma_R_nW;

    modport master (
        input  cpu_Addr_bus,
        input  cpu_Data_bus_out,
        input  cpu_R_nW,
        input  Data_bus_in,
        output rdy,
        output bus_sel,
        output dma_Addr_bus,
        output dma_Data_bus_out,
        output dma_R_nW
    );

    modport slave (
        output cpu_Addr_bus,
        output cpu_Data_bus_out,
        output cpu_R_nW,
        output Data_bus_in,
        input  rdy,
        input  bus_sel,
        input  dma_Addr_bus,
        input  dma_Data_bus_out,
        input  dma_R_nW
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite-DMA engine: snoops CPU writes to 0x4014, halts the CPU and copies one page to OAM.
// Define OAM_DMA_DBG_EN to add the dma_state_dbg / dma_idx_dbg observation ports.
module oam_dma (
    input  logic          clk_ph1,
    input  logic          rst,
`ifdef OAM_DMA_DBG_EN
    output logic [2:0]    dma_state_dbg,
    output logic [7:0]    dma_idx_dbg,
`endif
    oam_dma_if.master     bus
);

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;
    logic        par_q, par_d;

    logic        rdy_o;
    logic        bus_sel_o;
    logic [15:0] addr_o;
    logic [7:0]  data_o;
    logic        r_nw_o;
    logic        trigger;

    // Only a CPU-driven write seen while idle starts a transfer; DMA-owned cycles never do.
    always_comb begin
        trigger = (state_q == ST_IDLE) && !bus_sel_o && !bus.cpu_R_nW &&
                  (bus.cpu_Addr_bus == DMA_REG_ADDR);
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        latch_d = latch_q;
        par_d   = ~par_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    page_d  = bus.cpu_Data_bus_out;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // CPU write cycles cannot be halted, so wait for the first read cycle.
                if (bus.cpu_R_nW) begin
                    state_d = par_q ? ST_ALIGN : ST_READ;
                end
            end
            ST_ALIGN: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                latch_d = bus.Data_bus_in;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hff) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so nothing on the CPU side reaches them combinationally.
    always_comb begin
        rdy_o     = (state_q == ST_IDLE);
        bus_sel_o = 1'b0;
        addr_o    = 16'h0000;
        data_o    = 8'h00;
        r_nw_o    = 1'b1;

        case (state_q)
            ST_READ: begin
                bus_sel_o = 1'b1;
                addr_o    = {page_q, idx_q};
            end
            ST_WRITE: begin
                bus_sel_o = 1'b1;
                addr_o    = OAM_DATA_ADDR;
                data_o    = latch_q;
                r_nw_o    = 1'b0;
            end
            default: begin
                bus_sel_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            latch_q <= 8'h00;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            latch_q <= latch_d;
            par_q   <= par_d;
        end
    end

    assign bus.rdy              = rdy_o;
    assign bus.bus_sel          = bus_sel_o;
    assign bus.dma_Addr_bus     = addr_o;
    assign bus.dma_Data_bus_out = data_o;
    assign bus.dma_R_nW         = r_nw_o;

`ifdef OAM_DMA_DBG_EN
    assign dma_state_dbg = state_q;
    assign dma_idx_dbg   = idx_q;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected bus cycles, a negedge monitor pops and compares.
module tb_oam_dma;

    localparam logic [15:0] DMA_REG = 16'h4014;

    typedef struct packed {
        logic [15:0] addr;
        logic        rnw;
        logic [7:0]  data;
    } exp_t;

    logic clk_ph1;
    logic rst;
    logic tb_par;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    exp_t mon_e;

    oam_dma_if bus ();

`ifdef OAM_DMA_DBG_EN
    logic [2:0] dma_state_dbg;
    logic [7:0] dma_idx_dbg;
    oam_dma dut (
        .clk_ph1       (clk_ph1),
        .rst           (rst),
        .dma_state_dbg (dma_state_dbg),
        .dma_idx_dbg   (dma_idx_dbg),
        .bus           (bus.master)
    );
`else
    oam_dma dut (
        .clk_ph1 (clk_ph1),
        .rst     (rst),
        .bus     (bus.master)
    );
`endif

    // System memory: page 0x02 holds i^0x5A; other pages differ so a wrong page shows up.
    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'h02);
    endfunction

    logic [15:0] sys_addr;
    assign sys_addr        = bus.bus_sel ? bus.dma_Addr_bus : bus.cpu_Addr_bus;
    assign bus.Data_bus_in = mem_rd(sys_addr);

    initial begin
        clk_ph1 = 1'b0;
        forever #5 clk_ph1 = ~clk_ph1;
    end

    always @(posedge clk_ph1) begin
        tb_par <= rst ? 1'b0 : ~tb_par;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk_ph1) begin
        if (bus.bus_sel === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bus_cycle", {bus.dma_Addr_bus, 7'd0, bus.dma_R_nW, bus.dma_Data_bus_out}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("dma_addr", {16'd0, bus.dma_Addr_bus}, {16'd0, mon_e.addr});
                check("dma_rnw", {31'd0, bus.dma_R_nW}, {31'd0, mon_e.rnw});
                if (!mon_e.rnw) check("dma_wdata", {24'd0, bus.dma_Data_bus_out}, {24'd0, mon_e.data});
            end
        end else if (bus.bus_sel === 1'b0) begin
            check("idle_outputs", {7'd0, bus.dma_Addr_bus, bus.dma_Data_bus_out, bus.dma_R_nW},
                  {7'd0, 16'h0000, 8'h00, 1'b1});
        end
    end

    task automatic cpu_drive(input logic [15:0] a, input logic [7:0] d, input logic rnw);
        bus.cpu_Addr_bus     = a;
        bus.cpu_Data_bus_out = d;
        bus.cpu_R_nW         = rnw;
    endtask

    task automatic nomatch(input logic [15:0] a, input logic rnw, input string nm);
        @(posedge clk_ph1); #1;
        cpu_drive(a, 8'h02, rnw);
        @(posedge clk_ph1); #1;
        cpu_drive(16'h8000, 8'h00, 1'b1);
        @(negedge clk_ph1);
        check({nm, "_rdy"}, {31'd0, bus.rdy}, 32'd1);
        check({nm, "_bus_sel"}, {31'd0, bus.bus_sel}, 32'd0);
    endtask

    // One transfer of page pg; p is the parity wanted at the last HALT cycle, nw extra CPU writes.
    task automatic xfer(input logic [7:0] pg, input logic [7:0] key, input int p, input int nw,
                        input int inj_at, input int rst_at);
        int   lowc, haltc, guard, k, npairs;
        bit   first, did_rst;
        exp_t e;
        lowc = 0; haltc = 0; guard = 0; k = 0; first = 1'b1; did_rst = 1'b0;
        @(posedge clk_ph1); #1;
        while (int'(tb_par) != ((p + 1 + nw) % 2)) begin
            @(posedge clk_ph1); #1;
        end
        npairs = (rst_at >= 0) ? rst_at : 256;
        for (int i = 0; i < npairs; i++) begin
            e.addr = {pg, 8'(i)}; e.rnw = 1'b1; e.data = 8'h00;
            exp_q.push_back(e);
            e.addr = 16'h2004; e.rnw = 1'b0; e.data = 8'(i) ^ key;
            exp_q.push_back(e);
        end
        if (rst_at >= 0) begin
            e.addr = {pg, 8'(rst_at)}; e.rnw = 1'b1; e.data = 8'h00;
            exp_q.push_back(e);
        end
        cpu_drive(DMA_REG, pg, 1'b0);
        @(negedge clk_ph1);
        check("rdy_pre", {31'd0, bus.rdy}, 32'd1);
        do begin
            @(posedge clk_ph1); #1;
            if (k < nw) begin
                cpu_drive(16'h0300 + 16'(k), 8'hA0, 1'b0);
                k++;
            end else if (inj_at >= 0 && lowc == inj_at) begin
                cpu_drive(DMA_REG, 8'h03, 1'b0);
            end else begin
                cpu_drive(16'h8000, 8'h00, 1'b1);
            end
            @(negedge clk_ph1);
            if (first) check("rdy_fall", {31'd0, bus.rdy}, 32'd0);
            first = 1'b0;
            if (!bus.rdy) begin
                lowc++;
                if (!bus.bus_sel) haltc++;
            end
            guard++;
            if (rst_at >= 0 && bus.bus_sel && bus.dma_R_nW && bus.dma_Addr_bus[7:0] == 8'(rst_at)) begin
                rst = 1'b1;
                @(posedge clk_ph1); #1;
                rst = 1'b0;
                cpu_drive(16'h8000, 8'h00, 1'b1);
                @(negedge clk_ph1);
                check("rst_rdy", {31'd0, bus.rdy}, 32'd1);
                check("rst_bus_sel", {31'd0, bus.bus_sel}, 32'd0);
                did_rst = 1'b1;
            end
        end while (bus.rdy == 1'b0 && !did_rst && guard < 1000);
        check("timeout", {31'd0, guard < 1000}, 32'd1);
        if (rst_at < 0) begin
            check("stall_len", lowc, 513 + p + nw);
            check("halt_align_len", haltc, 1 + p + nw);
        end else begin
            check("rst_seen", {31'd0, did_rst}, 32'd1);
        end
        repeat (8) @(negedge clk_ph1);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        cpu_drive(16'h8000, 8'h00, 1'b1);
        repeat (2) @(posedge clk_ph1);
        #1;
        rst = 1'b0;
        @(negedge clk_ph1);
        check("reset_rdy", {31'd0, bus.rdy}, 32'd1);
        check("reset_bus_sel", {31'd0, bus.bus_sel}, 32'd0);
        check("reset_addr", {16'd0, bus.dma_Addr_bus}, 32'h0000);
        check("reset_wdata", {24'd0, bus.dma_Data_bus_out}, 32'h00);
        check("reset_rnw", {31'd0, bus.dma_R_nW}, 32'd1);
`ifdef OAM_DMA_DBG_EN
        check("reset_state_dbg", {29'd0, dma_state_dbg}, 32'd0);
        check("reset_idx_dbg", {24'd0, dma_idx_dbg}, 32'd0);
`endif

        nomatch(16'h4015, 1'b0, "wr_4015");
        nomatch(16'h4013, 1'b0, "wr_4013");
        nomatch(16'h4014, 1'b1, "rd_4014");

        xfer(8'h02, 8'h5A, 0, 0, -1, -1);
        xfer(8'h02, 8'h5A, 1, 0, -1, -1);
        xfer(8'h02, 8'h5A, 0, 2, -1, -1);
        xfer(8'h02, 8'h5A, 1, 2, -1, -1);
        xfer(8'h02, 8'h5A, 0, 0, 100, -1);
        xfer(8'h02, 8'h5A, 0, 0, -1, 8'h40);
        xfer(8'h02, 8'h5A, 1, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
